// File: rtl/io_bus_pkg.sv
// io_bus_pkg
// Shared definitions for the IO bus arbiter slice.
//   state_e          : arbiter FSM states (IDLE -> ACCESS -> DONE)
//   DEV_BASE_DEFAULT : lowest byte address of the device window
//   DEV_SIZE_DEFAULT : length of the device window in bytes
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [31:0] DEV_BASE_DEFAULT = 32'h0000_7F00;
  localparam logic [31:0] DEV_SIZE_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode
// Combinational device-window decoder.
//   BASE   : lowest byte address of the window
//   SIZE   : window length in bytes
//   addr_i : byte address to test
//   hit_o  : 1 when BASE <= addr_i < BASE+SIZE
module io_addr_decode #(
  parameter logic [31:0] BASE = 32'h0000_7F00,
  parameter logic [31:0] SIZE = 32'h0000_0100
) (
  input  logic [31:0] addr_i,
  output logic        hit_o
);

  // Bounds are widened to 33 bits so a window that touches the top of
  // the address space cannot wrap its upper limit back to a small value.
  localparam logic [32:0] LO = {1'b0, BASE};
  localparam logic [32:0] HI = {1'b0, BASE} + {1'b0, SIZE};

  logic [32:0] addrWide;

  assign addrWide = {1'b0, addr_i};
  assign hit_o    = (addrWide >= LO) && (addrWide < HI);

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
// Two-master round-robin arbiter in front of a single memory-mapped device.
// Each transaction takes one ACCESS cycle (bus driven, strobe issued) and one
// DONE cycle (completion pulse, read data and error reported).
//   clk, reset                      : clock, synchronous active-high reset
//   m0_*/m1_* req, we, addr, wdata  : requester inputs (m0 = CPU)
//   m0_*/m1_* gnt, done, err        : requester handshake outputs
//   rdata                           : 12-bit read data, valid with done
//   Address, DeviceData             : device bus, 0 outside ACCESS
//   writeEn, readEn                 : device strobes, in-window only
//   Device_Read_Data                : device read data, sampled end of ACCESS
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter logic [31:0] DEV_BASE = DEV_BASE_DEFAULT,
  parameter logic [31:0] DEV_SIZE = DEV_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic        m0_err,
  output logic        m1_err,
  output logic [11:0] rdata,
  output logic [31:0] Address,
  output logic [31:0] DeviceData,
  output logic        writeEn,
  output logic        readEn,
  input  logic [11:0] Device_Read_Data
);

  state_e      state_q;
  logic        owner_q;
  logic        rr_q;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic [1:0]  err_q;
  logic [11:0] rdata_q;

  logic [1:0]  req;
  logic        idleWinner_d;
  logic        other_d;
  logic [31:0] ownAddr;
  logic [31:0] ownWdata;
  logic        ownWe;
  logic        hit;
  logic        inAccess;

  assign req      = {m1_req, m0_req};
  assign other_d  = ~owner_q;
  assign inAccess = (state_q == ACCESS);

  // The preferred master wins if it is asking; otherwise the other one.
  assign idleWinner_d = req[rr_q] ? rr_q : ~rr_q;

  // Select the current owner's request fields for the device bus.
  always_comb begin
    ownAddr  = m0_addr;
    ownWdata = m0_wdata;
    ownWe    = m0_we;
    if (owner_q) begin
      ownAddr  = m1_addr;
      ownWdata = m1_wdata;
      ownWe    = m1_we;
    end
  end

  io_addr_decode #(
    .BASE(DEV_BASE),
    .SIZE(DEV_SIZE)
  ) u_decode (
    .addr_i(ownAddr),
    .hit_o (hit)
  );

  // Bus and strobes are gated by the ACCESS state so that a reset edge
  // drops them immediately; requesters hold their fields stable meanwhile.
  assign Address    = inAccess ? ownAddr  : 32'h0;
  assign DeviceData = inAccess ? ownWdata : 32'h0;
  assign writeEn    = inAccess & hit &  ownWe;
  assign readEn     = inAccess & hit & ~ownWe;

  // Arbiter FSM. gnt/done/err are one-cycle registered pulses cleared by
  // default every cycle and set only on the transition that needs them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= 12'h000;
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 2'b00;
      err_q  <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q               <= idleWinner_d;
            gnt_q[idleWinner_d]   <= 1'b1;
            state_q               <= ACCESS;
          end
        end
        ACCESS: begin
          state_q         <= DONE;
          rr_q            <= ~owner_q;
          rdata_q         <= (hit && !ownWe) ? Device_Read_Data : 12'h000;
          done_q[owner_q] <= 1'b1;
          err_q[owner_q]  <= ~hit;
        end
        DONE: begin
          // Only the waiting master may take the bus straight away; the
          // finishing owner's still-high req is deliberately ignored.
          if (req[other_d]) begin
            owner_q        <= other_d;
            gnt_q[other_d] <= 1'b1;
            state_q        <= ACCESS;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt  = gnt_q[0];
  assign m1_gnt  = gnt_q[1];
  assign m0_done = done_q[0];
  assign m1_done = done_q[1];
  assign m0_err  = err_q[0];
  assign m1_err  = err_q[1];
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter
// Scoreboard bench for io_bus_arbiter. Drivers push the expected outcome of
// each request into a per-master queue; a negedge monitor compares bus
// activity, grants and completions against those queues and against the
// arbitration rules (round-robin in idle, hand-over only to the waiting
// master after a completion, one transaction per two cycles).
module tb_io_bus_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [11:0] rdata;
  } txn_t;

  logic        clk;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [11:0] rdata;
  logic [31:0] Address, DeviceData;
  logic        writeEn, readEn;
  logic [11:0] Device_Read_Data;
  logic [11:0] dataKey;

  int testsRun;
  int failCount;

  txn_t q0[$];
  txn_t q1[$];
  int   doneLog[$];

  logic [1:0] prevReq, prevGnt, prevDone;
  logic       rrModel;

  io_bus_arbiter #(
    .DEV_BASE(32'h0000_7F00),
    .DEV_SIZE(32'h0000_0100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m0_req          (m0_req),
    .m1_req          (m1_req),
    .m0_we           (m0_we),
    .m1_we           (m1_we),
    .m0_addr         (m0_addr),
    .m1_addr         (m1_addr),
    .m0_wdata        (m0_wdata),
    .m1_wdata        (m1_wdata),
    .m0_gnt          (m0_gnt),
    .m1_gnt          (m1_gnt),
    .m0_done         (m0_done),
    .m1_done         (m1_done),
    .m0_err          (m0_err),
    .m1_err          (m1_err),
    .rdata           (rdata),
    .Address         (Address),
    .DeviceData      (DeviceData),
    .writeEn         (writeEn),
    .readEn          (readEn),
    .Device_Read_Data(Device_Read_Data)
  );

  // The device answers with a scrambled copy of the address it is shown.
  assign Device_Read_Data = Address[11:0] ^ dataKey;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit inWin(input logic [31:0] a);
    return (a >= 32'h0000_7F00) && (a <= 32'h0000_7FFF);
  endfunction

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0, 1, 2: a = 32'h0000_7F00 + 32'($urandom_range(0, 255));
      3:       a = 32'h0000_7EFF;
      4:       a = 32'h0000_8000;
      default: a = $urandom;
    endcase
    return a;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    testsRun++;
    failCount++;
    $display("[TB] FAIL %s: %s at %0t", name, detail, $time);
  endtask

  task automatic pushExp(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.err   = !inWin(addr);
    t.rdata = (!we && inWin(addr)) ? (addr[11:0] ^ dataKey) : 12'h000;
    if (m == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic setMaster(input int m, input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // Issue one transaction and hold it until its done pulse (called just
  // after a rising edge; returns just after a rising edge).
  task automatic applyStimulus(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int cycles;
    bit seen;
    pushExp(m, we, addr, wdata);
    setMaster(m, 1'b1, we, addr, wdata);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      cycles++;
      seen = (m == 0) ? m0_done : m1_done;
    end
    if (!seen) reportFail("doneTimeout", $sformatf("master %0d got no done, required one", m));
    @(posedge clk);
    #1;
    setMaster(m, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    setMaster(0, 1'b0, 1'b0, 32'h0, 32'h0);
    setMaster(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: checks every cycle against the queues and arbitration rules.
  always @(negedge clk) begin : monitor
    logic [1:0] curGnt, curDone, curErr, expG;
    logic       o;
    txn_t       h;
    bit         haveHead;
    curGnt  = {m1_gnt, m0_gnt};
    curDone = {m1_done, m0_done};
    curErr  = {m1_err, m0_err};
    if (reset) begin
      checkOutput("resetCtrl", {curGnt, curDone, curErr, writeEn, readEn}, 8'h00);
      checkOutput("resetBus", {Address, DeviceData}, 64'h0);
      checkOutput("resetRdata", rdata, 12'h000);
      q0.delete();
      q1.delete();
      prevReq  = 2'b00;
      prevGnt  = 2'b00;
      prevDone = 2'b00;
      rrModel  = 1'b0;
    end else begin
      expG = 2'b00;
      if (prevGnt != 2'b00) begin
        expG = 2'b00;
      end else if (prevDone != 2'b00) begin
        o = prevDone[1];
        if (prevReq[~o]) expG[~o] = 1'b1;
      end else if (prevReq[rrModel]) begin
        expG[rrModel] = 1'b1;
      end else if (prevReq[~rrModel]) begin
        expG[~rrModel] = 1'b1;
      end
      if (curGnt != 2'b00 || expG != 2'b00) checkOutput("grant", curGnt, expG);

      if (curGnt == 2'b01 || curGnt == 2'b10) begin
        o = curGnt[1];
        rrModel = ~o;
        haveHead = (o == 1'b0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!haveHead) begin
          reportFail("unexpectedGnt", $sformatf("gnt %b with no pending request, required none", curGnt));
        end else begin
          h = (o == 1'b0) ? q0[0] : q1[0];
          checkOutput("busAddr", Address, h.addr);
          checkOutput("busData", DeviceData, h.wdata);
          checkOutput("strobes", {writeEn, readEn},
                      {h.we && !h.err, !h.we && !h.err});
        end
      end else begin
        checkOutput("idleStrobes", {writeEn, readEn, Address}, 34'h0);
        checkOutput("idleData", DeviceData, 32'h0);
      end

      checkOutput("errMask", curErr & ~curDone, 2'b00);
      if (curDone != 2'b00) begin
        checkOutput("doneLatency", curDone, prevGnt);
        o = curDone[1];
        haveHead = (o == 1'b0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!haveHead) begin
          reportFail("unexpectedDone", $sformatf("done %b with no pending request, required none", curDone));
        end else begin
          h = (o == 1'b0) ? q0.pop_front() : q1.pop_front();
          checkOutput("doneErr", curErr[o], h.err);
          checkOutput("rdata", rdata, h.rdata);
          doneLog.push_back(int'(o));
        end
      end

      prevReq  = {m1_req, m0_req};
      prevGnt  = curGnt;
      prevDone = curDone;
    end
  end

  initial begin
    testsRun  = 0;
    failCount = 0;
    dataKey   = 12'h000;
    prevReq   = 2'b00;
    prevGnt   = 2'b00;
    prevDone  = 2'b00;
    rrModel   = 1'b0;
    doReset();

    // Single in-window write from m0, then an in-window read from m1.
    applyStimulus(0, 1'b1, 32'h0000_7F04, 32'h0000_00A5);
    repeat (2) @(posedge clk);
    #1;
    dataKey = 12'hF10 ^ 12'h3C5;
    applyStimulus(1, 1'b0, 32'h0000_7F10, 32'h0);

    // Window edges: one past the end and one below the base.
    applyStimulus(0, 1'b1, 32'h0000_8000, 32'h1111_2222);
    applyStimulus(0, 1'b1, 32'h0000_7EFF, 32'h3333_4444);
    applyStimulus(0, 1'b0, 32'h0000_7FFF, 32'h0);
    applyStimulus(1, 1'b0, 32'hFFFF_FFFF, 32'h0);

    // A one-cycle m1 pulse during m0's ACCESS must be ignored.
    fork
      applyStimulus(0, 1'b1, 32'h0000_7F20, 32'h0000_1234);
      begin
        int c;
        c = 0;
        while (!m0_gnt && c < 20) begin
          @(negedge clk);
          c++;
        end
        #1;
        setMaster(1, 1'b1, 1'b0, 32'h0000_7F30, 32'h0);
        @(posedge clk);
        #1;
        setMaster(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Simultaneous held requests after reset alternate starting with m0.
    doReset();
    doneLog.delete();
    fork
      begin
        applyStimulus(0, 1'b1, 32'h0000_7F50, 32'hAAAA_0001);
        applyStimulus(0, 1'b0, 32'h0000_7F54, 32'h0);
      end
      begin
        applyStimulus(1, 1'b1, 32'h0000_7F60, 32'hBBBB_0002);
        applyStimulus(1, 1'b0, 32'h0000_7F64, 32'h0);
      end
    join
    if (doneLog.size() == 4)
      checkOutput("rrOrder", {doneLog[0][0], doneLog[1][0], doneLog[2][0], doneLog[3][0]}, 4'b0101);
    else
      reportFail("rrOrder", $sformatf("got %0d completions, required 4", doneLog.size()));

    // Reset during ACCESS aborts; m0 must win first afterwards even though
    // the last completed owner was m0.
    applyStimulus(0, 1'b1, 32'h0000_7F70, 32'h0000_0777);
    pushExp(0, 1'b0, 32'h0000_7F44, 32'h0);
    setMaster(0, 1'b1, 1'b0, 32'h0000_7F44, 32'h0);
    begin
      int c;
      c = 0;
      while (!m0_gnt && c < 20) begin
        @(negedge clk);
        c++;
      end
      if (!m0_gnt) reportFail("abortGnt", "got no gnt, required gnt before reset");
    end
    #1;
    reset = 1'b1;
    setMaster(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    doneLog.delete();
    fork
      applyStimulus(0, 1'b0, 32'h0000_7F80, 32'h0);
      applyStimulus(1, 1'b1, 32'h0000_7F84, 32'h0000_0999);
    join
    if (doneLog.size() >= 1)
      checkOutput("postResetFirst", doneLog[0], 0);
    else
      reportFail("postResetFirst", "got no completion, required m0 first");

    // Randomized concurrent traffic from both masters.
    dataKey = 12'($urandom);
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int gap;
          gap = $urandom_range(0, 3);
          if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
          applyStimulus(0, 1'($urandom_range(0, 1)), randAddr(), $urandom);
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          int gap;
          gap = $urandom_range(0, 3);
          if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
          applyStimulus(1, 1'($urandom_range(0, 1)), randAddr(), $urandom);
        end
      end
    join

    repeat (4) @(posedge clk);
    #1;
    checkOutput("queuesDrained", 64'(q0.size() + q1.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
